// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame defaults, index width, state encoding and the bit-reverse helper.
package fft_pkg;

  localparam int unsigned FFT_N         = 64;
  localparam int unsigned FFT_W         = 16;
  localparam int unsigned FFT_IDX_W     = $clog2(FFT_N);
  localparam int unsigned FFT_MAX_IDX_W = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } fft_state_t;

  function automatic int unsigned fft_idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Reverses the low 'bits' bits of k; bits above 'bits' come back as zero.
  function automatic logic [FFT_MAX_IDX_W-1:0] bitrev(input logic [FFT_MAX_IDX_W-1:0] k,
                                                      input int unsigned bits);
    logic [FFT_MAX_IDX_W-1:0] r;
    logic [FFT_MAX_IDX_W-1:0] kk;
    r  = '0;
    kk = k;
    for (int unsigned i = 0; i < FFT_MAX_IDX_W; i++) begin
      if (i < bits) begin
        r = {r[FFT_MAX_IDX_W-2:0], kk[0]};
      end
      kk = kk >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_buffer.sv
// Collects N complex samples into a frame, pulses start, then holds the frame for HOLD_CYCLES.
// Define FFT_BITREV_EN to store the frame in bit-reversed order.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N           = FFT_N,
  parameter int unsigned W           = FFT_W,
  parameter int unsigned HOLD_CYCLES = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         in_ready,
  output logic [W-1:0] output_Re [N],
  output logic [W-1:0] output_Im [N],
  output logic         start,
  output logic [15:0]  frame_count
);

  localparam int unsigned IDX_W = fft_idx_width(N);
  localparam int unsigned HC_W  = $clog2(HOLD_CYCLES + 1);

  fft_state_t       state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] wr_addr;
  logic [HC_W-1:0]  hold_cnt_q;
  logic [15:0]      frame_cnt_q;
  logic             wr_en;
  logic             hold_done;

`ifdef FFT_BITREV_EN
  assign wr_addr = IDX_W'(bitrev(FFT_MAX_IDX_W'(wr_idx_q), IDX_W));
`else
  assign wr_addr = wr_idx_q;
`endif

  assign hold_done   = (hold_cnt_q == HC_W'(HOLD_CYCLES - 1));
  assign wr_en       = in_valid && in_ready;
  assign frame_count = frame_cnt_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    start    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx_q == IDX_W'(N - 1))) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_done) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        wr_idx_q <= (wr_idx_q == IDX_W'(N - 1)) ? '0 : wr_idx_q + IDX_W'(1);
      end
      if (state_q == HOLD) begin
        hold_cnt_q <= hold_done ? '0 : hold_cnt_q + HC_W'(1);
      end
      // Only written on launch so an externally preset count persists until then.
      if (state_q == LAUNCH) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        output_Re[i] <= '0;
        output_Im[i] <= '0;
      end
    end else if (wr_en) begin
      output_Re[wr_addr] <= in_re;
      output_Im[wr_addr] <= in_im;
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: directed scenarios plus randomized traffic vs a frame model.
module tb_fft_input_buffer;

  localparam int N    = 64;
  localparam int W    = 16;
  localparam int HOLD = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         in_ready;
  logic [W-1:0] o_re [N];
  logic [W-1:0] o_im [N];
  logic         start;
  logic [15:0]  frame_count;

  fft_input_buffer #(.N(N), .W(W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .in_ready(in_ready), .output_Re(o_re), .output_Im(o_im),
    .start(start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: frame contents, samples taken this frame, cycles since start (-1 = filling).
  logic [W-1:0] m_re [N];
  logic [W-1:0] m_im [N];
  int fill_k = 0;
  int since  = -1;
  int m_fc   = 0;

  logic last_ready;
  logic last_start;

  typedef struct {
    int           k;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } probe_t;
  probe_t probes [6];

  function automatic int pos(input int k);
`ifdef FFT_BITREV_EN
    int r = 0;
    for (int b = 0; b < $clog2(N); b++) r = r * 2 + ((k >> b) & 1);
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    int bad;
    @(negedge clk);
    rst = r; in_valid = v; in_re = re; in_im = im;
    #1;
    last_ready = in_ready;
    last_start = start;
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!r && since < 0));
      chk("start", 32'(start), 32'(!r && since == 0));
      chk("frame_count", 32'(frame_count), 32'(m_fc[15:0]));
      bad = 0;
      for (int i = N - 1; i >= 0; i--)
        if (o_re[i] !== m_re[i] || o_im[i] !== m_im[i]) bad = i;
      chk("frame_re", 32'(o_re[bad]), 32'(m_re[bad]));
      chk("frame_im", 32'(o_im[bad]), 32'(m_im[bad]));
    end
    @(posedge clk);
    if (r) begin
      fill_k = 0; since = -1; m_fc = 0;
      for (int i = 0; i < N; i++) begin m_re[i] = '0; m_im[i] = '0; end
    end else if (since < 0) begin
      if (v) begin
        m_re[pos(fill_k)] = re;
        m_im[pos(fill_k)] = im;
        fill_k++;
        if (fill_k == N) begin fill_k = 0; since = 0; end
      end
    end else begin
      if (since == 0) m_fc = (m_fc + 1) & 16'hFFFF;
      since++;
      if (since > HOLD) since = -1;
    end
  endtask

  initial begin
    int n;
    int acc;
    logic [W-1:0] rr, ii;

    probes[0] = '{k: 5,  re: 16'h0005, im: 16'hFFFB};
    probes[1] = '{k: 0,  re: 16'h0000, im: 16'h0000};
    probes[2] = '{k: 1,  re: 16'h0001, im: 16'hFFFF};
    probes[3] = '{k: 3,  re: 16'h0003, im: 16'hFFFD};
    probes[4] = '{k: 32, re: 16'h0020, im: 16'hFFE0};
    probes[5] = '{k: 63, re: 16'h003F, im: 16'hFFC1};

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
    step(1, 0, '0, '0);
    chk_en = 1'b1;
    step(1, 1, 16'h1111, 16'h2222);
    step(1, 0, '0, '0);

    // Back-to-back frame re=k, im=-k
    for (int k = 0; k < N; k++) step(0, 1, 16'(k), 16'(-k));
    step(0, 1, 16'h1234, 16'h5678);
    chk("start_after_last", 32'(last_start), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("probe_re[%0d]", probes[i].k), 32'(o_re[pos(probes[i].k)]), 32'(probes[i].re));
      chk($sformatf("probe_im[%0d]", probes[i].k), 32'(o_im[pos(probes[i].k)]), 32'(probes[i].im));
    end

    // Upstream holds a sample through HOLD; it must land in entry pos(0) of frame 2
    n = 0;
    do begin
      step(0, 1, 16'h1234, 16'h5678);
      n++;
    end while (!last_ready && n < 300);
    chk("ready_gap_after_start", 32'(n), 32'(HOLD + 1));
    chk("frame_count_one", 32'(frame_count), 32'd1);
    step(0, 0, '0, '0);
    chk("frame2_first_re", 32'(o_re[pos(0)]), 32'h1234);

    // Rest of frame 2 with in_valid toggling every cycle
    acc = 1;
    for (int i = 0; acc < N; i++) begin
      step(0, 1'(i % 2), 16'(100 + acc), 16'(200 + acc));
      if (i % 2 == 1) acc++;
    end
    step(0, 0, '0, '0);
    chk("toggle_start", 32'(last_start), 32'd1);
    for (int i = 0; i < HOLD; i++) step(0, 0, '0, '0);

    // Reset mid-fill discards 30 samples; fresh frame of 7s
    for (int k = 0; k < 30; k++) step(0, 1, 16'hDEAD, 16'hBEEF);
    step(1, 1, 16'hDEAD, 16'hBEEF);
    for (int k = 0; k < N; k++) step(0, 1, 16'd7, 16'd7);
    step(0, 0, '0, '0);
    chk("restart_start", 32'(last_start), 32'd1);
    n = 0;
    for (int i = 0; i < N; i++) if (o_re[i] !== 16'd7 || o_im[i] !== 16'd7) n++;
    chk("all_entries_seven", 32'(n), 32'd0);
    for (int i = 0; i < HOLD; i++) step(0, 0, '0, '0);

    // Randomized traffic with sparse resets
    for (int i = 0; i < 900; i++) begin
      rr = 16'($urandom);
      ii = 16'($urandom);
      step(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 9) < 6), rr, ii);
    end

    // Preset frame_count to 65535 and launch a frame to wrap it
    step(1, 0, '0, '0);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_fc = 16'hFFFF;
    for (int k = 0; k < N; k++) step(0, 1, 16'(3 * k), 16'(k));
    step(0, 0, '0, '0);
    chk("wrap_pre", 32'(frame_count), 32'hFFFF);
    step(0, 0, '0, '0);
    chk("wrap_post", 32'(frame_count), 32'h0000);
    for (int i = 0; i < 5; i++) step(0, 1, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter N, default 64, frame length in complex samples (power of two, 4..256).
REQ-002 SHALL have parameter W, default 16, bit width of each real or imaginary component.
REQ-003 SHALL have parameter HOLD_CYCLES, default 100, number of cycles the frame is held stable after start.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-007 SHALL have port in_re, input, W, real part of the sample.
REQ-008 SHALL have port in_im, input, W, imaginary part of the sample.
REQ-009 SHALL have port in_ready, output, 1, buffer accepts a sample this cycle.
REQ-010 SHALL have port output_Re, output, W x N unpacked array, real parts of the frame for the FFT.
REQ-011 SHALL have port output_Im, output, W x N unpacked array, imaginary parts of the frame for the FFT.
REQ-012 SHALL have port start, output, 1, one-cycle FFT launch pulse.
REQ-013 SHALL have port frame_count, output, 16, number of frames launched, wrapping at 65535.

Function
REQ-014 SHALL implement a state machine with states FILL, LAUNCH and HOLD.
REQ-015 In FILL, SHALL drive in_ready=1, and on in_valid&&in_ready SHALL write {in_re,in_im} to entry wr_idx and increment wr_idx.
REQ-016 In FILL, SHALL hold wr_idx and leave the array unchanged when in_valid=0; gaps of any length SHALL be tolerated.
REQ-017 In FILL, when the accepted sample has wr_idx=N-1, SHALL move to LAUNCH on the next edge and reset wr_idx to 0.
REQ-018 In LAUNCH, SHALL drive start=1 for exactly one cycle and in_ready=0, increment frame_count, and move to HOLD.
REQ-019 In HOLD, SHALL drive in_ready=0 and start=0, and count HOLD_CYCLES cycles, then return to FILL.
REQ-020 In LAUNCH and HOLD, SHALL keep output_Re and output_Im bit-stable.
REQ-021 SHALL make written samples visible on output_Re and output_Im one cycle after acceptance; latency from the last accepted sample to start=1 SHALL be 1 cycle.
REQ-022 SHALL not accept any sample while in_ready=0; in_valid asserted in that state SHALL be ignored, and upstream SHALL hold the sample.
REQ-023 SHALL allow frame_count to wrap from 65535 to 0 without side effects.
REQ-024 SHALL produce the first in_ready=1 of the next frame exactly 1+HOLD_CYCLES cycles after start.

Reset
REQ-025 On rst=1 at a clock edge, SHALL set state=FILL, wr_idx=0, hold counter=0, start=0, frame_count=0, and all output_Re/output_Im entries to 0.
REQ-026 SHALL drive in_ready=0 while rst=1.
REQ-027 SHALL discard a partially filled frame on a reset mid-FILL, and SHALL not emit start.
REQ-028 SHALL abort HOLD on a reset mid-HOLD, and SHALL resume in FILL on the first cycle after rst deasserts.

Configuration
REQ-029 With macro FFT_BITREV_EN defined, SHALL store the sample accepted at count k in entry bitrev(k) over log2(N) bits, presenting the frame in bit-reversed order.
REQ-030 Without FFT_BITREV_EN, SHALL store the sample accepted at count k in entry k (natural order).

Structure
REQ-031 SHALL take state enum, default N, W and the log2(N) index-width constant from shared package fft_pkg, which the FFT core also uses.
REQ-032 SHALL place the bit-reverse function in fft_pkg, and SHALL use no sub-module; the hold counter and fill counter are local registers.

Verification
REQ-033 Scenario: reset, then 64 back-to-back samples re=k, im=-k -> start high 1 cycle after sample 63; output_Re[5]=5, output_Im[5]=16'hFFFB; frame_count=1.
REQ-034 Scenario: in_valid toggled 1/0 every cycle for 64 samples -> start asserted 1 cycle after the 64th accepted sample; no sample lost or duplicated.
REQ-035 Scenario: in_valid held high through HOLD -> in_ready=0 for 101 cycles after start; first sample of frame 2 accepted on cycle 101 post-start and written to entry 0.
REQ-036 Scenario: rst pulsed after 30 samples, then 64 fresh samples value 7 -> no start before the 94th sample overall; all 64 entries equal 7.
REQ-037 Scenario: with FFT_BITREV_EN, sample count 1 (re=1) -> lands in output_Re[32]; sample count 3 -> lands in output_Re[48].
REQ-038 Scenario: force frame_count to 65535, then complete one frame -> frame_count=0.
